// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/IR owner.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               IorD;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSrc;
    logic               PCWrite;
    logic               Branch;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    // Handshake: mem_ready high in a wait state means the memory access
    // completes on the coming clock edge; the controller holds its outputs
    // stable (MemWrite included) until then.
    modport master (
        input  opcode, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch,
               illegal_op, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch,
               illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Control word is registered alongside the state; only the FETCH strobes see mem_ready.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       fetch;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_legal;

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic mr);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      n = S_EXEC;
                    OP_LW, OP_SW:  n = S_MEMADR;
                    OP_BEQ:        n = S_BRANCH;
                    OP_ADDI:       n = S_ADDIEX;
                    OP_J:          n = S_JUMP;
                    default:       n = S_FETCH;
                endcase
            end
            S_MEMADR: n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  n = mr ? S_MEMWB : S_MEMRD;
            S_MEMWR:  n = mr ? S_FETCH : S_MEMWR;
            S_EXEC:   n = S_ALUWB;
            S_ADDIEX: n = S_ADDIWB;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch   = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD:  c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next  = next_state(r_state, bus.opcode, bus.mem_ready);
        w_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                  (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                  (bus.opcode == OP_ADDI)  || (bus.opcode == OP_J);
        w_ctrl  = reset ? '0 : r_ctrl;
    end

    // The control word is precomputed from the next state so it is a flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= decode(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
        end
    end

    assign bus.IorD       = w_ctrl.iord;
    assign bus.MemWrite   = w_ctrl.memwrite;
    assign bus.IRWrite    = w_ctrl.fetch & bus.mem_ready;
    assign bus.RegDst     = w_ctrl.regdst;
    assign bus.MemtoReg   = w_ctrl.memtoreg;
    assign bus.RegWrite   = w_ctrl.regwrite;
    assign bus.ALUSrcA    = w_ctrl.alusrca;
    assign bus.ALUSrcB    = w_ctrl.alusrcb;
    assign bus.ALUOp      = w_ctrl.aluop;
    assign bus.PCSrc      = w_ctrl.pcsrc;
    assign bus.PCWrite    = w_ctrl.pcwrite | (w_ctrl.fetch & bus.mem_ready);
    assign bus.Branch     = w_ctrl.branch;
    assign bus.illegal_op = ~reset & (r_state == S_DECODE) & ~w_legal;
    assign bus.state_o    = reset ? '0 : STATE_W'(r_state);
endmodule
